// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared defaults, opcodes and FSM states for the pin allocator
package pio_pkg;

  localparam int PIO_NUM_CORES = 4;
  localparam int PIO_NUM_PINS  = 32;

  localparam logic [1:0] OP_CLAIM   = 2'b00;
  localparam logic [1:0] OP_RELEASE = 2'b01;
  localparam logic [1:0] OP_LOCK    = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } pio_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first request at or above ptr, with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    int               sum;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IDX_W'(sum);
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_pin_allocator.sv
// rtl/gpio_pin_allocator.sv - arbitrated all-or-nothing GPIO pin ownership map
// PIN_ALLOC_LOCK_EN enables the lock opcode and per-pin release locks.
module gpio_pin_allocator
  import pio_pkg::*;
#(
  parameter int NUM_CORES = PIO_NUM_CORES,
  parameter int NUM_PINS  = PIO_NUM_PINS,
  parameter int CORE_W    = $clog2(NUM_CORES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CORES-1:0]               req_valid,
  output logic [NUM_CORES-1:0]               req_ready,
  input  logic [NUM_CORES-1:0][1:0]          req_op,
  input  logic [NUM_CORES-1:0][NUM_PINS-1:0] req_mask,
  output logic [NUM_CORES-1:0]               resp_valid,
  output logic                               resp_ok,
  output logic [NUM_PINS-1:0]                resp_conflict,
  output logic [NUM_PINS-1:0][CORE_W-1:0]    core_select,
  output logic [NUM_PINS-1:0]                owned_mask
);

  pio_state_e                          state_q, state_d;
  logic [CORE_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [CORE_W-1:0]                   core_q, core_d;
  logic [1:0]                          op_q, op_d;
  logic [NUM_PINS-1:0]                 mask_q, mask_d;
  logic [NUM_PINS-1:0]                 owned_q, owned_d;
  logic [NUM_PINS-1:0][CORE_W-1:0]     sel_q, sel_d;
  logic [NUM_PINS-1:0]                 conflict_q, conflict_d;
  logic                                ok_q, ok_d;
`ifdef PIN_ALLOC_LOCK_EN
  logic [NUM_PINS-1:0]                 lock_q, lock_d;
`endif

  logic [NUM_CORES-1:0] grant;
  logic [CORE_W-1:0]    grant_idx;
  logic                 grant_any;
  logic [NUM_PINS-1:0]  mine;
  logic [NUM_PINS-1:0]  conflict;
  logic                 rsvd;

  rr_arbiter #(.NUM_REQ(NUM_CORES), .IDX_W(CORE_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Conflict set of the latched request against the current map.
  always_comb begin
    mine     = '0;
    conflict = '0;
    rsvd     = 1'b0;
    for (int p = 0; p < NUM_PINS; p++) begin
      mine[p] = owned_q[p] && (sel_q[p] == core_q);
    end
    case (op_q)
      OP_CLAIM:   conflict = mask_q & owned_q & ~mine;
`ifdef PIN_ALLOC_LOCK_EN
      OP_RELEASE: conflict = mask_q & (~mine | lock_q);
      OP_LOCK:    conflict = mask_q & ~mine;
`else
      OP_RELEASE: conflict = mask_q & ~mine;
`endif
      default: begin
        conflict = mask_q;
        rsvd     = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    core_d     = core_q;
    op_d       = op_q;
    mask_d     = mask_q;
    owned_d    = owned_q;
    sel_d      = sel_q;
    conflict_d = conflict_q;
    ok_d       = ok_q;
`ifdef PIN_ALLOC_LOCK_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          core_d   = grant_idx;
          op_d     = req_op[grant_idx];
          mask_d   = req_mask[grant_idx];
          rr_ptr_d = (grant_idx == CORE_W'(NUM_CORES - 1)) ? '0 : grant_idx + CORE_W'(1);
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        conflict_d = conflict;
        ok_d       = (conflict == '0) && !rsvd;
        if (ok_d) begin
          case (op_q)
            OP_CLAIM: begin
              owned_d = owned_q | mask_q;
              for (int p = 0; p < NUM_PINS; p++) if (mask_q[p]) sel_d[p] = core_q;
            end
            OP_RELEASE: begin
              owned_d = owned_q & ~mask_q;
              for (int p = 0; p < NUM_PINS; p++) if (mask_q[p]) sel_d[p] = '0;
            end
`ifdef PIN_ALLOC_LOCK_EN
            OP_LOCK: lock_d = lock_q | mask_q;
`endif
            default: ;
          endcase
        end
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      core_q     <= '0;
      op_q       <= OP_CLAIM;
      mask_q     <= '0;
      owned_q    <= '0;
      sel_q      <= '0;
      conflict_q <= '0;
      ok_q       <= 1'b0;
`ifdef PIN_ALLOC_LOCK_EN
      lock_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      core_q     <= core_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
      owned_q    <= owned_d;
      sel_q      <= sel_d;
      conflict_q <= conflict_d;
      ok_q       <= ok_d;
`ifdef PIN_ALLOC_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  // Ready is combinational from the arbiter but only offered in IDLE outside reset.
  assign req_ready     = (state_q == ST_IDLE && !rst) ? grant : '0;
  assign resp_valid    = (state_q == ST_RESP) ? (NUM_CORES'(1) << core_q) : '0;
  assign resp_ok       = (state_q == ST_RESP) && ok_q;
  assign resp_conflict = (state_q == ST_RESP) ? conflict_q : '0;
  assign core_select   = sel_q;
  assign owned_mask    = owned_q;

endmodule

// File: tb/tb_gpio_pin_allocator.sv
// tb/tb_gpio_pin_allocator.sv - randomized self-checking bench with an ownership-table model
module tb_gpio_pin_allocator;

  localparam int NC = 4;
  localparam int NP = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NC-1:0]          req_valid = '0;
  logic [NC-1:0]          req_ready;
  logic [NC-1:0][1:0]     req_op = '0;
  logic [NC-1:0][NP-1:0]  req_mask = '0;
  logic [NC-1:0]          resp_valid;
  logic                   resp_ok;
  logic [NP-1:0]          resp_conflict;
  logic [NP-1:0][1:0]     core_select;
  logic [NP-1:0]          owned_mask;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int            m_owner[NP];
  bit            m_lock[NP];
  int            rr_model;
  logic [1:0]    op_a[NC];
  logic [NP-1:0] mask_a[NC];

  gpio_pin_allocator dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_mask      (req_mask),
    .resp_valid    (resp_valid),
    .resp_ok       (resp_ok),
    .resp_conflict (resp_conflict),
    .core_select   (core_select),
    .owned_mask    (owned_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_owner[p] = -1;
      m_lock[p]  = 1'b0;
    end
    rr_model = 0;
  endtask

  function automatic logic [NP-1:0] exp_owned();
    logic [NP-1:0] e;
    for (int p = 0; p < NP; p++) e[p] = (m_owner[p] >= 0);
    return e;
  endfunction

  function automatic logic [2*NP-1:0] exp_sel();
    logic [2*NP-1:0] e;
    for (int p = 0; p < NP; p++) e[2*p +: 2] = (m_owner[p] < 0) ? 2'd0 : 2'(m_owner[p]);
    return e;
  endfunction

  task automatic model_eval(input int c, input logic [1:0] op, input logic [NP-1:0] m,
                            output logic [NP-1:0] conf, output logic ok);
    logic rsvd;
    conf = '0;
    rsvd = (op == 2'b11);
`ifndef PIN_ALLOC_LOCK_EN
    if (op == 2'b10) rsvd = 1'b1;
`endif
    for (int p = 0; p < NP; p++) begin
      if (m[p]) begin
        if (rsvd) conf[p] = 1'b1;
        else if (op == 2'b00) conf[p] = (m_owner[p] >= 0) && (m_owner[p] != c);
        else if (op == 2'b01) conf[p] = (m_owner[p] != c) || m_lock[p];
        else conf[p] = (m_owner[p] != c);
      end
    end
    ok = (conf == '0) && !rsvd;
  endtask

  task automatic model_apply(input int c, input logic [1:0] op, input logic [NP-1:0] m);
    for (int p = 0; p < NP; p++) begin
      if (m[p]) begin
        if (op == 2'b00) m_owner[p] = c;
        else if (op == 2'b01) m_owner[p] = -1;
        else if (op == 2'b10) m_lock[p] = 1'b1;
      end
    end
  endtask

  // Presents op_a/mask_a for every core in the set and serves them to completion.
  task automatic serve(input logic [NC-1:0] set);
    logic [NC-1:0] pend;
    logic [NP-1:0] conf;
    logic          ok;
    int            n;
    int            w;
    int            last_acc;
    pend = set;
    last_acc = -1;
    for (int c = 0; c < NC; c++) begin
      if (set[c]) begin
        req_valid[c] = 1'b1;
        req_op[c]    = op_a[c];
        req_mask[c]  = mask_a[c];
      end
    end
    #1;
    while (pend != '0) begin
      n = 0;
      while (req_ready == '0 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 20) begin
        check("ready_timeout", 64'(req_ready), 64'(1));
        req_valid = '0;
        return;
      end
      w = -1;
      for (int i = 0; i < NC; i++) begin
        if (w < 0 && pend[(rr_model + i) % NC]) w = (rr_model + i) % NC;
      end
      check("grant", 64'(req_ready), 64'(1) << w);
      if (last_acc >= 0) check("spacing", 64'(cyc - last_acc), 64'(3));
      last_acc = cyc;
      model_eval(w, op_a[w], mask_a[w], conf, ok);
      @(negedge clk);
      req_valid[w] = 1'b0;
      check("check_no_resp", 64'(resp_valid), 64'(0));
      check("check_no_ready", 64'(req_ready), 64'(0));
      check("check_owned_old", 64'(owned_mask), 64'(exp_owned()));
      @(negedge clk);
      if (ok) model_apply(w, op_a[w], mask_a[w]);
      check("resp_valid", 64'(resp_valid), 64'(1) << w);
      check("resp_ok", 64'(resp_ok), 64'(ok));
      check("resp_conflict", 64'(resp_conflict), 64'(conf));
      check("owned", 64'(owned_mask), 64'(exp_owned()));
      check("core_select", 64'(core_select), 64'(exp_sel()));
      rr_model = (w + 1) % NC;
      pend[w] = 1'b0;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic one(input int c, input logic [1:0] op, input logic [NP-1:0] m);
    op_a[c] = op;
    mask_a[c] = m;
    serve(NC'(1) << c);
  endtask

  initial begin
    int            n;
    logic [NC-1:0] set;
    int            r;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_owned", 64'(owned_mask), 64'(0));
    check("rst_sel", 64'(core_select), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_resp", {31'd0, resp_ok, 28'd0, resp_valid}, 64'(0));
    check("rst_conf", 64'(resp_conflict), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    one(1, 2'b00, 32'h0000_00F0);
    check("plan_claim_owned", 64'(owned_mask), 64'h0000_00F0);
    check("plan_claim_sel", 64'(core_select), 64'h0000_5500);
    one(2, 2'b00, 32'h0000_0180);
    check("plan_atomic_owned", 64'(owned_mask), 64'h0000_00F0);
    one(3, 2'b00, 32'h0);

    op_a = '{2'b00, 2'b00, 2'b00, 2'b00};
    mask_a[0] = 32'h0000_0F00;
    mask_a[1] = 32'h0000_F000;
    mask_a[2] = 32'h000F_0000;
    mask_a[3] = 32'h00F0_0000;
    serve(4'hF);
    check("plan_rr_owned", 64'(owned_mask), 64'h00FF_FFF0);

    one(1, 2'b01, 32'h0000_00F0);
    one(3, 2'b01, 32'h0000_0001);

    one(0, 2'b00, 32'h0000_0003);
    one(0, 2'b10, 32'h0000_0001);
    one(0, 2'b01, 32'h0000_0003);
    one(0, 2'b10, 32'h0);
    one(2, 2'b11, 32'h0);
    one(2, 2'b00, 32'h0000_0F00);

    for (int it = 0; it < 60; it++) begin
      set = NC'($urandom_range(1, 15));
      for (int c = 0; c < NC; c++) begin
        r = $urandom_range(0, 9);
        op_a[c] = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
        mask_a[c] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_00FF);
      end
      serve(set);
    end

    one(1, 2'b00, 32'hF000_0000);
    req_valid[1] = 1'b1;
    req_op[1]    = 2'b00;
    req_mask[1]  = 32'h0F00_0000;
    #1;
    n = 0;
    while (req_ready[1] !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("midrst_ready", 64'(n < 20), 64'(1));
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_owned", 64'(owned_mask), 64'(0));
    check("midrst_sel", 64'(core_select), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_resp", 64'(resp_valid), 64'(0));
    end
    check("midrst_owned_after", 64'(owned_mask), 64'(0));
    one(2, 2'b00, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
